muldiv_unit: RTL

Iterative multiply/divide execution unit that owns the architectural HI/LO registers. It sits in EX beside the ALU.
- It consumes the decoded MULT/MULTU/DIV/DIVU operations (RegDst = PROD), plus MTHI/MTLO writes.
- It provides HI/LO to MFHI/MFLO (DataDst = HIGH_OUT/LOW_OUT).
- It exposes a start/busy/done handshake so the hazard logic can stall the pipeline while a result is pending.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_step.sv | 28 ++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Quotient returned on a zero divisor.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_if.sv
// Command/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// acc layout: multiply {partial, multiplier}; divide {remainder, quotient/dividend}.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // Single-step datapath; the remainder never reaches 2*divisor so XLEN+1 bits suffice.
  always_comb begin
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    trial = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff  = trial - {1'b0, opnd_i};
    if (!is_div_i) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  md_op_e            op_q, op_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic              a_neg, b_neg, in_mul;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] step_acc, prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q[1]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  // Operand magnitudes and result signs for the incoming op (op[0]=0 means signed).
  always_comb begin
    in_mul = ~bus.op[1];
    a_neg  = ~bus.op[0] & bus.src_a[XLEN-1];
    b_neg  = ~bus.op[0] & bus.src_b[XLEN-1];
    a_mag  = a_neg ? -bus.src_a : bus.src_a;
    b_mag  = b_neg ? -bus.src_b : bus.src_b;
  end

  // Sign correction of the finished result; remainder follows the dividend.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = {{XLEN{1'b0}}, acc_q[XLEN-1:0]} * {{XLEN{1'b0}}, opnd_q};
`else
    prod = acc_q;
`endif
    prod_s = q_neg_q ? -prod : prod;
    if (opnd_q == '0) begin
      quot_s = XLEN'(DIV0_QUOT);
    end else begin
      quot_s = q_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    end
    rem_s = r_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  // FSM next state, iteration datapath and HI/LO writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    done_d  = 1'b0;
    hi_d    = bus.hi_we ? bus.wdata : hi_q;
    lo_d    = bus.lo_we ? bus.wdata : lo_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_d    = md_op_e'(bus.op);
            opnd_d  = in_mul ? a_mag : b_mag;
            acc_d   = {{XLEN{1'b0}}, (in_mul ? b_mag : a_mag)};
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            cnt_d   = '0;
            state_d = CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (in_mul) state_d = FIX;
`endif
          end
        end
        CALC: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
        end
        FIX: begin
          if (op_q[1]) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end else begin
            hi_d = prod_s[2*XLEN-1:XLEN];
            lo_d = prod_s[XLEN-1:0];
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= MD_MULT;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
